multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control unit for the CPU datapath: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the ALU's operation select (`ALUFlag`) and B-operand select (`ALUSrcB`) and consumes the ALU's `zero` flag, so it sits at the opposite end of the ALU control interface. It also drives the PC, IR, register-file and data-memory enables.

## Interface
- No parameters. Opcode values, ALU flag codes and state codes are constants in `cpu_ctrl_pkg`.
- `clk` input 1: single clock. All state changes occur on the rising edge.
- `reset` input 1: synchronous, active-high. State becomes IF on the first edge at which `reset` is sampled high.
- `opcode` input 6: `IR[31:26]`. Stable from the cycle after IF until the next IF.
- `zero` input 1: ALU zero flag, combinational from the ALU.
- `PCWre` output 1: PC write enable.
- `IRWre` output 1: IR write enable.
- `ALUSrcB` output 1: ALU B operand select; 0 = `readData2`, 1 = `immediate_32`.
- `ALUFlag` output 3: ALU operation; 000 add, 001 sub, 011 or, 100 and.
- `ExtSel` output 1: immediate extension; 1 = sign-extend, 0 = zero-extend.
- `RegDst` output 1: destination register; 1 = rd, 0 = rt.
- `RegWre` output 1: register-file write enable.
- `DBDataSrc` output 1: write-back source; 0 = ALU result, 1 = memory data.
- `mRD` output 1: data-memory read enable.
- `mWR` output 1: data-memory write enable.
- `PCSrc` output 2: next-PC select; 00 = PC+4, 01 = PC+4+(simm<<2), 10 = jump target.
- `halted` output 1: high while the FSM is in the HALT state.

## Operation
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sw 100110, lw 100111
  - beq 110000, j 111000, halt 111111
- Decode from `opcode` only; these outputs are valid in every state:
  - `ALUFlag`: add/addi/lw/sw → 000; sub/beq → 001; or/ori → 011; and → 100; any other opcode → 000.
  - `ALUSrcB` = 1 for addi, ori, lw, sw.
  - `ExtSel` = 0 for ori only.
  - `RegDst` = 1 for add, sub, or, and.
  - `DBDataSrc` = 1 for lw only.
- States: IF, ID, EXE_AL, EXE_LS, EXE_BR, MEM, WB_AL, WB_LD, HALT.
- Transitions:
  - IF → ID.
  - ID → EXE_AL for add, sub, addi, or, and, ori.
  - ID → EXE_LS for lw, sw.
  - ID → EXE_BR for beq.
  - ID → IF for j and for unknown opcodes.
  - ID → HALT for halt.
  - EXE_AL → WB_AL; EXE_LS → MEM; EXE_BR → IF.
  - MEM → WB_LD for lw; MEM → IF for sw.
  - WB_AL → IF; WB_LD → IF.
  - HALT → HALT until reset.
- Enables and PC control by state. Every enable not listed is 0; `PCSrc` is 00 unless listed.
  - IF: `IRWre` = 1.
  - ID, opcode j: `PCWre` = 1, `PCSrc` = 10.
  - ID, unknown opcode: `PCWre` = 1, `PCSrc` = 00 (executes as a nop).
  - EXE_BR: `PCWre` = 1; `PCSrc` = 01 if `zero`, else 00.
  - MEM, lw: `mRD` = 1.
  - MEM, sw: `mWR` = 1, `PCWre` = 1.
  - WB_AL and WB_LD: `RegWre` = 1, `PCWre` = 1.
  - HALT: all enables 0; `halted` = 1.
- `zero` is sampled only in EXE_BR.

## Timing
- All enable and PC outputs decode combinationally from the state register. The decoded ALU fields depend only on `opcode`.
- Reset:
  - While `reset` is high: `PCWre`, `IRWre`, `RegWre`, `mRD`, `mWR` = 0 and `PCSrc` = 00, regardless of state.
  - After the reset edge, state = IF and `halted` = 0.
  - Reset mid-instruction abandons the instruction: no `RegWre` or `mWR` pulse follows, and the first cycle after reset deasserts is IF.
- Cycles per instruction:
  - j or unknown opcode: 2
  - beq: 3
  - R-type, immediate ALU, sw: 4
  - lw: 5
- `PCWre` pulses exactly once per instruction, in its final cycle. `IRWre` pulses only in IF.
- `ALUFlag` and `ALUSrcB` hold from ID through the final cycle, so the ALU result is stable at WB and MEM.

## Structure
- `cpu_ctrl_pkg` holds:
  - opcode localparams
  - ALU flag codes (ADD/SUB/OR/AND)
  - state encoding (4-bit)
  - `PCSrc` codes
- One sub-module, `ctrl_decode`: a purely combinational opcode → {`ALUFlag`, `ALUSrcB`, `ExtSel`, `RegDst`, `DBDataSrc`, instruction class} decoder.
- `multicycle_ctrl` holds the state register, the next-state logic and the per-state enables.

## Test plan
- Reset held 3 cycles, then released with opcode 000000 → enables 0 during reset; then IF (`IRWre`=1), ID, EXE_AL with `ALUFlag`=000, WB_AL with `RegWre`=1, `PCWre`=1, `RegDst`=1.
- lw (100111) → 5-cycle trace; MEM has `mRD`=1; WB_LD has `RegWre`=1, `DBDataSrc`=1, `ALUSrcB`=1, `ExtSel`=1. sw (100110) → 4 cycles; MEM has `mWR`=1, `PCWre`=1, `RegWre` never 1.
- beq with `zero`=1 → EXE_BR has `PCSrc`=01, `ALUFlag`=001. Repeat with `zero`=0 → `PCSrc`=00; both take 3 cycles.
- ori (010010) → `ExtSel`=0, `ALUFlag`=011, `ALUSrcB`=1. j (111000) → ID has `PCWre`=1, `PCSrc`=10; next state IF.
- Opcode 101010 → ID has `PCWre`=1, `PCSrc`=00, returns to IF. halt (111111) → `halted`=1, enables stay 0 for 10 cycles; reset returns to IF.
- Reset asserted in MEM of an sw → no `mWR` pulse after the reset edge; state IF.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU controller: opcodes, ALU codes,
// FSM state encoding, next-PC select codes and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_LS = 4'd3,
    S_EXE_BR = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_J    = 3'd5,
    CLS_HALT = 3'd6
  } cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: ALU controls, datapath selects and the
// instruction class that steers the sequencing FSM.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] ALUFlag,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       DBDataSrc,
  output cls_e       cls
);

  always_comb begin
    ALUFlag   = ALU_ADD;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    RegDst    = 1'b0;
    DBDataSrc = 1'b0;
    cls       = CLS_NOP;
    case (opcode)
      OP_ADD:  begin cls = CLS_ALU; RegDst = 1'b1; end
      OP_SUB:  begin cls = CLS_ALU; RegDst = 1'b1; ALUFlag = ALU_SUB; end
      OP_ADDI: begin cls = CLS_ALU; ALUSrcB = 1'b1; end
      OP_OR:   begin cls = CLS_ALU; RegDst = 1'b1; ALUFlag = ALU_OR; end
      OP_AND:  begin cls = CLS_ALU; RegDst = 1'b1; ALUFlag = ALU_AND; end
      OP_ORI:  begin cls = CLS_ALU; ALUSrcB = 1'b1; ALUFlag = ALU_OR; ExtSel = 1'b0; end
      OP_SW:   begin cls = CLS_SW; ALUSrcB = 1'b1; end
      OP_LW:   begin cls = CLS_LW; ALUSrcB = 1'b1; DBDataSrc = 1'b1; end
      OP_BEQ:  begin cls = CLS_BR; ALUFlag = ALU_SUB; end
      OP_J:    cls = CLS_J;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and decodes the
// per-state enables; ALU fields come straight from the opcode decoder.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ALUSrcB,
  output logic [2:0] ALUFlag,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       RegWre,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic       halted
);

  state_e state_q, state_d;
  cls_e   cls;

  ctrl_decode u_decode (
    .opcode    (opcode),
    .ALUFlag   (ALUFlag),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .RegDst    (RegDst),
    .DBDataSrc (DBDataSrc),
    .cls       (cls)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (cls)
          CLS_ALU:        state_d = S_EXE_AL;
          CLS_LW, CLS_SW: state_d = S_EXE_LS;
          CLS_BR:         state_d = S_EXE_BR;
          CLS_HALT:       state_d = S_HALT;
          default:        state_d = S_IF;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_EXE_BR: state_d = S_IF;
      S_MEM:    state_d = (cls == CLS_LW) ? S_WB_LD : S_IF;
      S_WB_AL:  state_d = S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Reset gates every enable combinationally so nothing fires in the reset cycle.
  always_comb begin
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    PCSrc  = PC_SEQ;
    if (!reset) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (cls == CLS_J) begin
            PCWre = 1'b1;
            PCSrc = PC_JMP;
          end else if (cls == CLS_NOP) begin
            PCWre = 1'b1;
          end
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = zero ? PC_BR : PC_SEQ;
        end
        S_MEM: begin
          if (cls == CLS_LW) begin
            mRD = 1'b1;
          end else begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB_AL, S_WB_LD: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted = (state_q == S_HALT);

endmodule
